csr_reg_block: RTL
==================

CSR_REG_BLOCK -- requirements
Module: csr_reg_block

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: bus data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 11: byte-address width.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..15: extra cycles inserted before each response.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 bus_req  input  1  one-cycle request strobe.
REQ-008 bus_req_is_wr  input  1  1 = write, 0 = read; valid with bus_req.
REQ-009 bus_addr  input  ADDR_WIDTH  byte address; valid with bus_req.
REQ-010 bus_wr_data  input  DATA_WIDTH  write data; valid with bus_req.
REQ-011 bus_wr_biten  input  DATA_WIDTH/8  byte enables; valid with bus_req.
REQ-012 hw_event  input  8  per-bit interrupt event pulses.
REQ-013 bus_ready  output  1  one-cycle response strobe.
REQ-014 bus_err  output  1  error flag; meaningful only while bus_ready=1.
REQ-015 bus_rd_data  output  DATA_WIDTH  read data; meaningful only while bus_ready=1.
REQ-016 irq  output  1  level interrupt equal to |(IRQ_STAT & CTRL.IRQ_MASK).

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly when WAIT_STATES=0.
REQ-018 In IDLE, bus_req=1 SHALL capture is_wr, addr, wr_data and biten, and SHALL snapshot the read value, all in the request cycle N.
REQ-019 WAIT SHALL last exactly WAIT_STATES cycles, timed by a down-counter.
REQ-020 bus_ready SHALL pulse high for exactly one cycle, at cycle N+1+WAIT_STATES (state RESP).
REQ-021 A write SHALL commit on the clock edge that ends the RESP cycle, and only if bus_err=0.
REQ-022 The register map SHALL be:
- 0x000 CTRL (RW): bit0 CNT_EN; bit1 CNT_CLR, self-clearing one cycle after commit; [15:8] IRQ_MASK.
- 0x004 STATUS (RO): bit0 PROTO_ERR (sticky); [15:8] IRQ_STAT & IRQ_MASK.
- 0x008 SCRATCH (RW).
- 0x00C IRQ_STAT (W1C).
- 0x010 COUNTER (RO).
REQ-023 Bits not listed in REQ-022 SHALL read 0 and ignore writes.
REQ-024 An RW or W1C write SHALL affect only the byte lanes whose biten bit is 1.
REQ-025 bus_err=1 SHALL be returned, with bus_rd_data=0 and no state change, when any of these holds:
- addr[1:0] != 0;
- the address is unmapped;
- the access is a write to STATUS or COUNTER.
REQ-026 IRQ_STAT[i] SHALL set when hw_event[i]=1; when a set and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-027 COUNTER SHALL increment by 1 per cycle while CNT_EN=1, wrap from 0xFFFFFFFF to 0, and clear to 0 when CNT_CLR commits; clear SHALL take priority over increment.
REQ-028 A read of COUNTER SHALL return its value at cycle N, not at the response cycle.
REQ-029 A bus_req arriving outside IDLE SHALL be ignored (no response generated) and SHALL set STATUS.PROTO_ERR.
REQ-030 A write of 1 to STATUS bit0 SHALL NOT clear PROTO_ERR; only rst clears it.

Reset
REQ-031 On rst, every output and register SHALL go to 0 asynchronously and the FSM SHALL go to IDLE.
REQ-032 Outputs affected by rst SHALL be: bus_ready, bus_err, bus_rd_data, irq.
REQ-033 A transaction in flight when rst asserts SHALL be dropped, with no bus_ready and no write committed.
REQ-034 The first request SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-035 Package csr_reg_pkg SHALL hold:
- register offset constants;
- CTRL/STATUS field bit-position constants;
- the FSM state enum (IDLE, WAIT, RESP).
REQ-036 The block SHALL be a single module with no sub-module; the byte-lane write-merge logic SHALL be a function in csr_reg_pkg.

Verification
REQ-037 Scenario: WAIT_STATES=1; write 0xA5A5A5A5 to 0x008 with biten=0xF, then read 0x008 -> bus_ready 2 cycles after each bus_req; read returns 0xA5A5A5A5 with err=0.
REQ-038 Scenario: SCRATCH=0xA5A5A5A5; write 0x11223344 to 0x008 with biten=0x5 -> read returns 0xA522A544.
REQ-039 Scenario: write 0x0 to 0x010; read 0x014; read 0x002 -> each returns bus_err=1 with bus_rd_data=0, and COUNTER is unchanged.
REQ-040 Scenario: CTRL=0x0100; pulse hw_event[0] -> irq=1; write 0x1 to 0x00C in the same cycle as another hw_event[0] pulse -> bit stays 1; a later W1C with no event -> irq=0.
REQ-041 Scenario: CTRL=0x1 for 10 cycles, then write CTRL=0x3 -> COUNTER reads 0 on the next read; a second bus_req during WAIT -> no extra bus_ready and STATUS reads 0x1.
REQ-042 Scenario: assert rst during WAIT of a SCRATCH write -> no bus_ready, SCRATCH reads 0, and the first post-reset read succeeds.

Source files
------------

// File: rtl/csr_reg_pkg.sv
// ---------------------------------------------------------------------------
// csr_reg_pkg
// Shared definitions for the CSR register block:
//   - byte offsets of every mapped register
//   - CTRL / STATUS field bit positions
//   - bus-handshake FSM state encoding
//   - per-byte-lane write-merge helper used by RW and W1C writes
// ---------------------------------------------------------------------------
package csr_reg_pkg;

  // Register byte offsets
  localparam int CSR_CTRL_OFF     = 'h000;
  localparam int CSR_STATUS_OFF   = 'h004;
  localparam int CSR_SCRATCH_OFF  = 'h008;
  localparam int CSR_IRQ_STAT_OFF = 'h00C;
  localparam int CSR_COUNTER_OFF  = 'h010;

  // One-hot select positions produced by the address decoder
  localparam int SEL_CTRL     = 0;
  localparam int SEL_STATUS   = 1;
  localparam int SEL_SCRATCH  = 2;
  localparam int SEL_IRQ_STAT = 3;
  localparam int SEL_COUNTER  = 4;
  localparam int SEL_W        = 5;

  // CTRL fields
  localparam int CTRL_CNT_EN_BIT   = 0;
  localparam int CTRL_CNT_CLR_BIT  = 1;
  localparam int CTRL_IRQ_MASK_LSB = 8;

  // STATUS fields
  localparam int STATUS_PROTO_ERR_BIT = 0;
  localparam int STATUS_IRQ_LSB       = 8;

  // Number of interrupt sources
  localparam int IRQ_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } csr_state_t;

  // Merge one byte lane: take the new byte when its enable is set,
  // otherwise keep the old one. A W1C clear mask is obtained by merging
  // against an all-zero old value.
  function automatic logic [7:0] merge_lane(
    input logic [7:0] old_byte,
    input logic [7:0] new_byte,
    input logic       lane_en
  );
    return lane_en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/csr_reg_block.sv
// ---------------------------------------------------------------------------
// csr_reg_block
// Small memory-mapped control/status register block with a single
// outstanding request and a fixed, parameterised response latency.
//
// Parameters
//   DATA_WIDTH  : bus data width in bits (multiple of 8, at least 16)
//   ADDR_WIDTH  : byte-address width
//   WAIT_STATES : extra cycles between request and response (0..15)
//
// Ports
//   clk           : clock, all state updates on the rising edge
//   rst           : asynchronous active-high reset
//   bus_req       : one-cycle request strobe (accepted only in IDLE)
//   bus_req_is_wr : 1 = write, 0 = read
//   bus_addr      : byte address
//   bus_wr_data   : write data
//   bus_wr_biten  : per-byte write enables
//   hw_event      : per-bit interrupt event pulses
//   bus_ready     : one-cycle response strobe
//   bus_err       : error flag, valid with bus_ready
//   bus_rd_data   : read data, valid with bus_ready (0 on error)
//   irq           : |(IRQ_STAT & CTRL.IRQ_MASK)
// ---------------------------------------------------------------------------
module csr_reg_block
  import csr_reg_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 11,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bus_req,
  input  logic                    bus_req_is_wr,
  input  logic [ADDR_WIDTH-1:0]   bus_addr,
  input  logic [DATA_WIDTH-1:0]   bus_wr_data,
  input  logic [DATA_WIDTH/8-1:0] bus_wr_biten,
  input  logic [IRQ_W-1:0]        hw_event,
  output logic                    bus_ready,
  output logic                    bus_err,
  output logic [DATA_WIDTH-1:0]   bus_rd_data,
  output logic                    irq
);

  localparam int BYTES = DATA_WIDTH / 8;
  // The down-counter is loaded with WAIT_STATES-1 so that WAIT spans
  // exactly WAIT_STATES cycles (it leaves WAIT once the count reaches 0).
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  csr_state_t state_reg, state_next;
  logic [3:0] wait_cnt_reg;

  // Captured request
  logic                  req_wr_reg;
  logic                  req_err_reg;
  logic [ADDR_WIDTH-1:0] req_addr_reg;
  logic [DATA_WIDTH-1:0] req_wdata_reg;
  logic [BYTES-1:0]      req_biten_reg;
  logic [DATA_WIDTH-1:0] rsp_data_reg;

  // Architectural registers
  logic                  cnt_en_reg;
  logic                  cnt_clr_reg;
  logic [IRQ_W-1:0]      irq_mask_reg;
  logic [IRQ_W-1:0]      irq_stat_reg;
  logic                  proto_err_reg;
  logic [DATA_WIDTH-1:0] scratch_reg;
  logic [DATA_WIDTH-1:0] counter_reg;

  // -------------------------------------------------------------------------
  // Address decode (one-hot); misaligned addresses never match an offset
  // -------------------------------------------------------------------------
  function automatic logic [SEL_W-1:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic [SEL_W-1:0] sel;
    sel               = '0;
    sel[SEL_CTRL]     = (a == ADDR_WIDTH'(CSR_CTRL_OFF));
    sel[SEL_STATUS]   = (a == ADDR_WIDTH'(CSR_STATUS_OFF));
    sel[SEL_SCRATCH]  = (a == ADDR_WIDTH'(CSR_SCRATCH_OFF));
    sel[SEL_IRQ_STAT] = (a == ADDR_WIDTH'(CSR_IRQ_STAT_OFF));
    sel[SEL_COUNTER]  = (a == ADDR_WIDTH'(CSR_COUNTER_OFF));
    return sel;
  endfunction

  logic [SEL_W-1:0] in_sel;
  logic [SEL_W-1:0] cur_sel;
  logic             in_err;

  assign in_sel  = decode(bus_addr);
  assign cur_sel = decode(req_addr_reg);

  always_comb begin
    in_err = 1'b0;
    if (bus_addr[1:0] != 2'b00) begin
      in_err = 1'b1;
    end else if (in_sel == '0) begin
      in_err = 1'b1;
    end else if (bus_req_is_wr && (in_sel[SEL_STATUS] || in_sel[SEL_COUNTER])) begin
      in_err = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Register read views
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] ctrl_val;
  logic [DATA_WIDTH-1:0] status_val;
  logic [DATA_WIDTH-1:0] irq_stat_val;
  logic [DATA_WIDTH-1:0] rd_snap;

  always_comb begin
    ctrl_val                                   = '0;
    ctrl_val[CTRL_CNT_EN_BIT]                  = cnt_en_reg;
    ctrl_val[CTRL_CNT_CLR_BIT]                 = cnt_clr_reg;
    ctrl_val[CTRL_IRQ_MASK_LSB +: IRQ_W]       = irq_mask_reg;

    status_val                                 = '0;
    status_val[STATUS_PROTO_ERR_BIT]           = proto_err_reg;
    status_val[STATUS_IRQ_LSB +: IRQ_W]        = irq_stat_reg & irq_mask_reg;

    irq_stat_val                               = '0;
    irq_stat_val[IRQ_W-1:0]                    = irq_stat_reg;
  end

  // Read value as seen in the request cycle; errors return zero
  always_comb begin
    rd_snap = '0;
    if (!in_err) begin
      if (in_sel[SEL_CTRL])     rd_snap = ctrl_val;
      if (in_sel[SEL_STATUS])   rd_snap = status_val;
      if (in_sel[SEL_SCRATCH])  rd_snap = scratch_reg;
      if (in_sel[SEL_IRQ_STAT]) rd_snap = irq_stat_val;
      if (in_sel[SEL_COUNTER])  rd_snap = counter_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Write merge against the currently targeted register. For IRQ_STAT the
  // old value is zero, so the merge yields the W1C clear mask.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] old_sel;
  logic [DATA_WIDTH-1:0] wr_merged;

  always_comb begin
    old_sel = '0;
    if (cur_sel[SEL_CTRL])    old_sel = ctrl_val;
    if (cur_sel[SEL_SCRATCH]) old_sel = scratch_reg;
  end

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign wr_merged[gi*8 +: 8] = merge_lane(old_sel[gi*8 +: 8],
                                               req_wdata_reg[gi*8 +: 8],
                                               req_biten_reg[gi]);
    end
  endgenerate

  // Writes commit on the edge that ends the RESP cycle
  logic commit;
  logic commit_ctrl;
  logic commit_scratch;
  logic commit_w1c;
  logic cnt_clear;

  assign commit         = (state_reg == RESP) && req_wr_reg && !req_err_reg;
  assign commit_ctrl    = commit && cur_sel[SEL_CTRL];
  assign commit_scratch = commit && cur_sel[SEL_SCRATCH];
  assign commit_w1c     = commit && cur_sel[SEL_IRQ_STAT];
  assign cnt_clear      = commit_ctrl && wr_merged[CTRL_CNT_CLR_BIT];

  logic accept;
  assign accept = (state_reg == IDLE) && bus_req;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus_req) begin
          state_next = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt_reg == 4'd0) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg  <= 4'd0;
      req_wr_reg    <= 1'b0;
      req_err_reg   <= 1'b0;
      req_addr_reg  <= '0;
      req_wdata_reg <= '0;
      req_biten_reg <= '0;
      rsp_data_reg  <= '0;
      cnt_en_reg    <= 1'b0;
      cnt_clr_reg   <= 1'b0;
      irq_mask_reg  <= '0;
      irq_stat_reg  <= '0;
      proto_err_reg <= 1'b0;
      scratch_reg   <= '0;
      counter_reg   <= '0;
    end else begin
      if (accept) begin
        req_wr_reg    <= bus_req_is_wr;
        req_err_reg   <= in_err;
        req_addr_reg  <= bus_addr;
        req_wdata_reg <= bus_wr_data;
        req_biten_reg <= bus_wr_biten;
        rsp_data_reg  <= rd_snap;
        wait_cnt_reg  <= WAIT_INIT;
      end else if ((state_reg == WAIT) && (wait_cnt_reg != 4'd0)) begin
        wait_cnt_reg <= wait_cnt_reg - 4'd1;
      end

      // A request while a transaction is in flight is dropped but flagged
      if (bus_req && (state_reg != IDLE)) begin
        proto_err_reg <= 1'b1;
      end

      if (commit_ctrl) begin
        cnt_en_reg   <= wr_merged[CTRL_CNT_EN_BIT];
        irq_mask_reg <= wr_merged[CTRL_IRQ_MASK_LSB +: IRQ_W];
      end

      // CNT_CLR is visible for one cycle after it commits, then drops
      cnt_clr_reg <= commit_ctrl ? wr_merged[CTRL_CNT_CLR_BIT] : 1'b0;

      if (commit_scratch) begin
        scratch_reg <= wr_merged;
      end

      // New events override a simultaneous W1C clear
      irq_stat_reg <= (irq_stat_reg & ~(commit_w1c ? wr_merged[IRQ_W-1:0] : '0)) | hw_event;

      if (cnt_clear) begin
        counter_reg <= '0;
      end else if (cnt_en_reg) begin
        counter_reg <= counter_reg + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus_ready   = (state_reg == RESP);
  assign bus_err     = bus_ready & req_err_reg;
  assign bus_rd_data = bus_ready ? rsp_data_reg : '0;
  assign irq         = |(irq_stat_reg & irq_mask_reg);

endmodule
